game_session_ctrl: RTL
======================

// Module: game_session_ctrl
// PURPOSE
//  Sequences the note-memory game datapath across a multi-round session.
//  Per round: clears the datapath, generates a pseudo-random 8-note pattern, loads it, and starts play.
//  It then forwards keypad presses, watches for round completion, and aborts on player inactivity.
//  Sits between the board top (start button, keypad decoder) and the game datapath.
// PARAMETERS
//  NOTES       8        notes per pattern; the loaded word is NOTES*4 bits wide
//  TIMEOUT_CYC 1000     idle cycles in RUN before abort; must be >= 2
//  MAX_ROUNDS  3        rounds per session, 1..15
//  LFSR_SEED   16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clk             in   1         clock
//  reset           in   1         asynchronous, active-high reset
//  start_req       in   1         session start request; honoured only in IDLE
//  key_strobe      in   1         1-cycle pulse, one per key press
//  key_code        in   4         note code, valid while key_strobe is high
//  music_busy_in   in   1         high while the datapath is playing the pattern back
//  game_end_in     in   1         datapath reports that the round is complete
//  game_rst_out    out  1         1-cycle pulse that clears the datapath
//  pattern_out     out  NOTES*4   pattern word; note i occupies bits [4i+3:4i]
//  pattern_we      out  1         1-cycle write strobe for pattern_out
//  game_start_out  out  1         1-cycle start strobe to the datapath
//  keypad_en_out   out  1         1-cycle forwarded key strobe
//  keypad_code_out out  4         forwarded key code, held until the next forward
//  round_out       out  4         index of the current round, starting at 0
//  score_out       out  8         count of completed rounds, saturates at 255
//  timeout_out     out  1         sticky abort flag; cleared when a start_req is accepted
//  busy_out        out  1         high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, lfsr=LFSR_SEED, timer=0; every output is 0.
//  All outputs are registered. A strobe is high exactly during the cycles the FSM spends in the named state.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts left every cycle in every state, so the pattern depends on start time.
//  States:
//  - IDLE: start_req -> CLR. On entry to CLR, score_out, round_out and timeout_out are cleared.
//  - CLR: game_rst_out=1 for 1 cycle -> GEN.
//  - GEN: lasts exactly NOTES cycles; note k is generated in GEN cycle k.
//    Note value = lfsr[3:0], with 0 replaced by 4'h1 (0 means silence).
//    After the last note -> LOAD.
//  - LOAD: pattern_we=1 for 1 cycle, with pattern_out stable -> START.
//  - START: game_start_out=1 for 1 cycle; timer is cleared -> RUN.
//  - RUN, key forwarding: key_strobe accepted with music_busy_in=0 -> keypad_en_out=1 in the next cycle.
//    keypad_code_out takes key_code, and timer is cleared.
//  - RUN, busy keys: key_strobe with music_busy_in=1 is dropped silently.
//  - RUN, timer: increments only while music_busy_in=0 and holds while music_busy_in=1.
//    At timer==TIMEOUT_CYC-1 with no accepted key and no game_end_in -> ABORT.
//  - RUN, round end: game_end_in -> DONE.
//  - DONE: score_out+1, saturating. If round_out+1 < MAX_ROUNDS, round_out+1 -> CLR; otherwise -> IDLE.
//  - ABORT: timeout_out is set -> IDLE. round_out and score_out are held for display.
//  Latency: start_req sampled -> game_rst_out next cycle -> 8 GEN cycles.
//   pattern_we comes 9 cycles after game_rst_out; game_start_out the cycle after that.
//  Same edge, game_end_in and key_strobe: game_end_in wins and the key is not forwarded.
//  Same edge, game_end_in and timeout: game_end_in wins, giving DONE rather than ABORT.
//  start_req outside IDLE is ignored. Keys outside RUN are ignored.
//  game_end_in outside RUN is ignored.
//  Reset mid-session: immediate return to IDLE with all strobes low; a partial pattern is discarded.
//  Timer width is clog2(TIMEOUT_CYC+1). round_out never exceeds MAX_ROUNDS-1.
// TESTING
//  T1 start_req in IDLE -> game_rst_out at +1, pattern_we at +10, game_start_out at +11, busy_out=1.
//  T2 pattern_we -> pattern_out matches the LFSR model for the start cycle; no nibble is 4'h0.
//  T3 RUN, music_busy_in=0, key_strobe with key_code=4'h5 -> next cycle keypad_en_out=1, keypad_code_out=5.
//     Same press with music_busy_in=1 -> no forward.
//  T4 RUN, no keys, music_busy_in=0, TIMEOUT_CYC=16 -> ABORT after 16 cycles.
//     Result: timeout_out=1 and busy_out=0; busy pulses mid-count stretch the wait.
//  T5 MAX_ROUNDS=3, pulse game_end_in in each RUN -> rounds 0,1,2 run with a CLR between each.
//     After the third: score_out=3, busy_out=0.
//  T6 reset asserted in GEN -> all outputs 0 at once, no pattern_we.
//     Same-cycle game_end_in+key_strobe -> DONE, no keypad_en_out.

Source files
------------

// File: rtl/game_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_session_ctrl
//  Purpose  : Multi-round session sequencer for the note-memory game datapath:
//             clear, pattern generation, load, start, key forwarding, timeout.
//  Revision : 1.0  initial release
// ============================================================================
module game_session_ctrl #(
    parameter int          NOTES       = 8,
    parameter int          TIMEOUT_CYC = 1000,
    parameter int          MAX_ROUNDS  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_req,
    input  logic                 key_strobe,
    input  logic [3:0]           key_code,
    input  logic                 music_busy_in,
    input  logic                 game_end_in,
    output logic                 game_rst_out,
    output logic [NOTES*4-1:0]   pattern_out,
    output logic                 pattern_we,
    output logic                 game_start_out,
    output logic                 keypad_en_out,
    output logic [3:0]           keypad_code_out,
    output logic [3:0]           round_out,
    output logic [7:0]           score_out,
    output logic                 timeout_out,
    output logic                 busy_out
);

    localparam int c_timer_w = $clog2(TIMEOUT_CYC + 1);
    localparam int c_gen_w   = (NOTES > 1) ? $clog2(NOTES) : 1;

    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYC - 1);
    localparam logic [c_timer_w-1:0] c_timer_one  = c_timer_w'(1);
    localparam logic [c_gen_w-1:0]   c_gen_last   = c_gen_w'(NOTES - 1);
    localparam logic [c_gen_w-1:0]   c_gen_one    = c_gen_w'(1);
    localparam logic [3:0]           c_round_last = 4'(MAX_ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_GEN   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_START = 3'd4,
        ST_RUN   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ABORT = 3'd7
    } state_t;

    state_t                 state_q,        state_d;
    logic [15:0]            lfsr_q,         lfsr_d;
    logic [c_timer_w-1:0]   timer_q,        timer_d;
    logic [c_gen_w-1:0]     gen_cnt_q,      gen_cnt_d;
    logic [NOTES*4-1:0]     pattern_buf_q,  pattern_buf_d;
    logic [NOTES*4-1:0]     pattern_out_q,  pattern_out_d;
    logic                   game_rst_q,     game_rst_d;
    logic                   pattern_we_q,   pattern_we_d;
    logic                   game_start_q,   game_start_d;
    logic                   keypad_en_q,    keypad_en_d;
    logic [3:0]             keypad_code_q,  keypad_code_d;
    logic [3:0]             round_q,        round_d;
    logic [7:0]             score_q,        score_d;
    logic                   timeout_q,      timeout_d;
    logic                   busy_q,         busy_d;

    logic [3:0]             w_note;

    // A zero nibble would be a silent note, so it is promoted to 1.
    assign w_note = (lfsr_q[3:0] == 4'h0) ? 4'h1 : lfsr_q[3:0];

    always_comb begin
        state_d       = state_q;
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        timer_d       = timer_q;
        gen_cnt_d     = gen_cnt_q;
        pattern_buf_d = pattern_buf_q;
        pattern_out_d = pattern_out_q;
        keypad_en_d   = 1'b0;
        keypad_code_d = keypad_code_q;
        round_d       = round_q;
        score_d       = score_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d   = ST_CLR;
                    score_d   = 8'd0;
                    round_d   = 4'd0;
                    timeout_d = 1'b0;
                end
            end
            ST_CLR: begin
                state_d       = ST_GEN;
                gen_cnt_d     = '0;
                pattern_buf_d = '0;
            end
            ST_GEN: begin
                for (int i = 0; i < NOTES; i++) begin
                    if (gen_cnt_q == c_gen_w'(i)) begin
                        pattern_buf_d[4*i +: 4] = w_note;
                    end
                end
                gen_cnt_d = gen_cnt_q + c_gen_one;
                if (gen_cnt_q == c_gen_last) begin
                    state_d       = ST_LOAD;
                    pattern_out_d = pattern_buf_d;
                end
            end
            ST_LOAD: begin
                state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
            ST_RUN: begin
                // Round completion outranks both a coincident key and a timeout.
                if (game_end_in) begin
                    state_d = ST_DONE;
                end else if (key_strobe && !music_busy_in) begin
                    keypad_en_d   = 1'b1;
                    keypad_code_d = key_code;
                    timer_d       = '0;
                end else if (!music_busy_in) begin
                    if (timer_q == c_timer_last) begin
                        state_d   = ST_ABORT;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q + c_timer_one;
                    end
                end
            end
            ST_DONE: begin
                if (score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
                if (round_q < c_round_last) begin
                    round_d = round_q + 4'd1;
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                timeout_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered from the next state so each one is high
        // for exactly the cycles spent in its state.
        game_rst_d   = (state_d == ST_CLR);
        pattern_we_d = (state_d == ST_LOAD);
        game_start_d = (state_d == ST_START);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lfsr_q        <= LFSR_SEED;
            timer_q       <= '0;
            gen_cnt_q     <= '0;
            pattern_buf_q <= '0;
            pattern_out_q <= '0;
            game_rst_q    <= 1'b0;
            pattern_we_q  <= 1'b0;
            game_start_q  <= 1'b0;
            keypad_en_q   <= 1'b0;
            keypad_code_q <= 4'h0;
            round_q       <= 4'd0;
            score_q       <= 8'd0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            timer_q       <= timer_d;
            gen_cnt_q     <= gen_cnt_d;
            pattern_buf_q <= pattern_buf_d;
            pattern_out_q <= pattern_out_d;
            game_rst_q    <= game_rst_d;
            pattern_we_q  <= pattern_we_d;
            game_start_q  <= game_start_d;
            keypad_en_q   <= keypad_en_d;
            keypad_code_q <= keypad_code_d;
            round_q       <= round_d;
            score_q       <= score_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign game_rst_out    = game_rst_q;
    assign pattern_out     = pattern_out_q;
    assign pattern_we      = pattern_we_q;
    assign game_start_out  = game_start_q;
    assign keypad_en_out   = keypad_en_q;
    assign keypad_code_out = keypad_code_q;
    assign round_out       = round_q;
    assign score_out       = score_q;
    assign timeout_out     = timeout_q;
    assign busy_out        = busy_q;

endmodule
`default_nettype wire
